seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Reader side of the 4-digit display register: takes the four 4-bit digits held by the digit shift register and time-multiplexes them onto one shared 7-segment bus plus four digit commons.
- Snapshots the digits once per frame (no tearing), decodes hex 0-F, blanks leading zeros, and inserts a ghosting guard interval between digits.
- Sits between the digit shift register and the board's common-cathode/anode display pins.

Parameters:
- CLK_HZ, 27000000, system clock frequency.
- SCAN_HZ, 1000, per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ cycles per digit slot.
- GUARD, 16, cycles at the start of each slot with all commons inactive; GUARD < DIV.
- SEG_ACTIVE_LOW, 1, invert seg and dp at the pins when 1.
- COM_ACTIVE_LOW, 1, invert com at the pins when 1.
- BLANK_LEADING, 1, enable leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- en  in  1  scan enable; 0 = display dark.
- dig0  in  4  rightmost digit (newest shifted-in value).
- dig1  in  4  second digit from right.
- dig2  in  4  third digit from right.
- dig3  in  4  leftmost digit (oldest value).
- dp_mask  in  4  decimal point per digit; bit i belongs to dig i.
- seg  out  7  {g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, registered, polarity per SEG_ACTIVE_LOW.
- com  out  4  digit commons; bit i drives digit i; registered, polarity per COM_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when slot 3 completes.

Behaviour:
- States are IDLE, GUARD and SHOW. Registers are cnt (0..DIV-1), idx (0..3), snap (16 bits) and snap_dp (4 bits).
- Reset (rst=1 at a clock edge):
  - Go to IDLE; cnt=0, idx=0, snap=0, snap_dp=0.
  - Outputs inactive: seg and dp off, com all off, frame_done=0.
  - Reset takes precedence over everything, including mid-slot operation.
- IDLE:
  - Outputs inactive.
  - When en=1: capture snap/snap_dp from the inputs this cycle, set idx=0 and cnt=0, and enter GUARD next cycle. If GUARD=0, enter SHOW instead.
- GUARD:
  - com all off; seg and dp off.
  - cnt increments each cycle; at cnt==GUARD-1, go to SHOW with cnt=GUARD.
- SHOW:
  - com[idx] active, others off; seg/dp from the decoded snap digit idx and snap_dp[idx].
  - At cnt==DIV-1: cnt=0, idx=idx+1 mod 4, and enter GUARD (or SHOW if GUARD=0).
- Frame wrap (idx 3->0):
  - frame_done=1 for exactly that cycle.
  - snap/snap_dp re-captured from the inputs in the same cycle.
  - Input changes mid-frame never appear until the next frame.
- Output timing: all outputs are registered and reflect state one cycle after the state/cnt transition. Each digit slot is exactly DIV cycles, with GUARD dark cycles followed by DIV-GUARD lit cycles.
- en=0 in any state: go to IDLE next cycle; outputs inactive on the following cycle. An in-progress frame is abandoned and frame_done is not pulsed.
- Decode (active-high, before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading blank (BLANK_LEADING=1), evaluated on snap:
  - digit 3 blanked if 0.
  - digit 2 blanked if it and digit 3 are 0.
  - digit 1 blanked if it, digit 2 and digit 3 are 0.
  - digit 0 is never blanked.
  - A blanked slot drives seg off, but com is still active and dp is still shown.
- Widths: cnt is $clog2(DIV) bits; idx wraps naturally in 2 bits.

Test Plan:
(bench params: CLK_HZ=40, SCAN_HZ=4, so DIV=10; GUARD=2; both polarities active-low)
- Reset/idle: rst=1 then en=0 for 50 cycles -> seg=7F, dp=1, com=F, frame_done=0 throughout.
- Basic scan: en=1, dig3..0=1,2,3,4, dp_mask=0.
  - Slot 0: 2 cycles com=F, then 8 cycles com=E with seg=~4F(7-bit)=30.
  - Slot 1: com=D with seg=~5B=24.
  - Slots 2 and 3 follow the same pattern.
  - frame_done pulses once every 40 cycles.
- Snapshot: change dig0 from 4 to 9 during slot 2 -> slot 0 shows 4 until the frame wraps, then seg=~6F=10.
- Leading blank: dig3..0=0,0,0,0 -> slots 3,2,1 drive seg=7F with com still cycling; slot 0 shows seg=40. Then dig3..0=0,5,0,0 -> slots 2,1,0 lit, slot 3 blank.
- Hex and dp: dig0=B, dp_mask=0001 -> slot 0 seg=~7C=03, dp=0; other slots dp=1.
- Mid-operation abort: drop en during slot 1 SHOW -> within 2 cycles com=F, seg=7F, no frame_done. rst asserted mid-slot 2 -> same outputs, and restart begins at slot 0 with GUARD.

Source files
------------

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
//
// Reader side of the 4-digit display register. Takes the four 4-bit digits
// held by the digit shift register and time-multiplexes them onto one shared
// 7-segment bus plus four digit commons.
//
//   * The digits and decimal-point mask are snapshotted once per frame, when
//     scanning starts and again when slot 3 wraps back to slot 0, so a frame
//     never shows a mix of old and new digits.
//   * Each digit slot lasts DIV = CLK_HZ/SCAN_HZ cycles: GUARD dark cycles
//     (all commons off, so the previous digit's segments cannot ghost onto
//     the next common), then DIV-GUARD lit cycles.
//   * Hex 0-F decode; optional leading-zero blanking on the snapshot.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   en         in   scan enable; 0 = display dark
//   dig0..dig3 in   digits, dig0 rightmost (newest), dig3 leftmost (oldest)
//   dp_mask    in   decimal point per digit, bit i belongs to dig i
//   seg        out  {g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW
//   dp         out  decimal point, registered, polarity per SEG_ACTIVE_LOW
//   com        out  digit commons, bit i drives digit i, registered,
//                   polarity per COM_ACTIVE_LOW
//   frame_done out  one-cycle pulse when slot 3 completes
// -----------------------------------------------------------------------------
module seg_scan #(
    parameter int CLK_HZ         = 27000000,
    parameter int SCAN_HZ        = 1000,
    parameter int GUARD          = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int COM_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dp_mask,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] com,
    output logic       frame_done
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [CNT_W-1:0] GUARD_CNT  = CNT_W'(GUARD);

    // Pin levels that mean "off" for each polarity choice.
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1  : 1'b0;
    localparam logic [3:0] COM_OFF = (COM_ACTIVE_LOW != 0) ? 4'hF  : 4'h0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_SHOW
    } state_t;

    // With no guard interval every slot goes straight to the lit phase.
    localparam state_t SLOT_START = (GUARD == 0) ? S_SHOW : S_GUARD;

    // Active-high segment pattern {g,f,e,d,c,b,a} for a hex digit.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       idx_q,     idx_d;
    logic [15:0]      snap_q,    snap_d;
    logic [3:0]       snap_dp_q, snap_dp_d;

    logic [6:0]       seg_q,        seg_d;
    logic             dp_q,         dp_d;
    logic [3:0]       com_q,        com_d;
    logic             frame_done_q, frame_done_d;

    logic [15:0]      dig_in;
    assign dig_in = {dig3, dig2, dig1, dig0};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        snap_dp_d    = snap_dp_q;
        frame_done_d = 1'b0;

        if (!en) begin
            // Abandon whatever frame is in progress; no frame_done.
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    snap_d    = dig_in;
                    snap_dp_d = dp_mask;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    state_d   = SLOT_START;
                end

                S_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = S_SHOW;
                        cnt_d   = GUARD_CNT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_SHOW: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        state_d = SLOT_START;
                        // Frame wrap: the only point (besides start-up) where
                        // new digits are taken, so a frame never tears.
                        if (idx_q == 2'd3) begin
                            frame_done_d = 1'b1;
                            snap_d       = dig_in;
                            snap_dp_d    = dp_mask;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (from current state; registered below, so the pins lag the
    // state by one cycle)
    // -------------------------------------------------------------------------
    logic [3:0] cur_dig;
    logic       cur_dp;
    logic [3:0] blank;
    logic [6:0] seg_ah;
    logic       dp_ah;
    logic [3:0] com_ah;

    always_comb begin
        cur_dig = 4'h0;
        cur_dp  = 1'b0;
        case (idx_q)
            2'd0: begin cur_dig = snap_q[3:0];   cur_dp = snap_dp_q[0]; end
            2'd1: begin cur_dig = snap_q[7:4];   cur_dp = snap_dp_q[1]; end
            2'd2: begin cur_dig = snap_q[11:8];  cur_dp = snap_dp_q[2]; end
            default: begin cur_dig = snap_q[15:12]; cur_dp = snap_dp_q[3]; end
        endcase
    end

    // A digit is a leading zero only if it and every digit to its left are 0.
    // The rightmost digit always shows, so a value of zero reads "0".
    always_comb begin
        blank = 4'b0000;
        if (BLANK_LEADING != 0) begin
            blank[3] = (snap_q[15:12] == 4'h0);
            blank[2] = blank[3] && (snap_q[11:8] == 4'h0);
            blank[1] = blank[2] && (snap_q[7:4] == 4'h0);
        end
    end

    always_comb begin
        seg_ah = 7'h00;
        dp_ah  = 1'b0;
        com_ah = 4'b0000;
        if (state_q == S_SHOW) begin
            // A blanked digit keeps its common and decimal point so a value
            // like "  .5" still renders its dp.
            com_ah[idx_q] = 1'b1;
            seg_ah        = blank[idx_q] ? 7'h00 : hex_decode(cur_dig);
            dp_ah         = cur_dp;
        end
    end

    always_comb begin
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
        dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_ah  : dp_ah;
        com_d = (COM_ACTIVE_LOW != 0) ? ~com_ah : com_ah;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            snap_q       <= 16'h0000;
            snap_dp_q    <= 4'h0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            com_q        <= COM_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            snap_dp_q    <= snap_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            com_q        <= com_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign com        = com_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan
//
// Bench for seg_scan with CLK_HZ=40, SCAN_HZ=4 (DIV=10), GUARD=2 and
// active-low segments and commons. Each scenario builds the expected
// per-cycle pin stream {seg,dp,com,frame_done} into a scoreboard queue; an
// entry may also carry new input values to drive once that cycle is sampled.
// -----------------------------------------------------------------------------
module tb_seg_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [3:0] dp_mask;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] com;
    logic       frame_done;

    always #5 clk = ~clk;

    seg_scan #(
        .CLK_HZ        (40),
        .SCAN_HZ       (4),
        .GUARD         (2),
        .SEG_ACTIVE_LOW(1),
        .COM_ACTIVE_LOW(1),
        .BLANK_LEADING (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dig0      (dig0),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3),
        .dp_mask   (dp_mask),
        .seg       (seg),
        .dp        (dp),
        .com       (com),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [12:0] exp;    // {seg, dp, com, frame_done}
        bit          act;    // drive the a_* values after sampling this cycle
        logic        a_en;
        logic        a_rst;
        logic [15:0] a_dig;  // {dig3, dig2, dig1, dig0}
        logic [3:0]  a_dpm;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [12:0] DARK = {7'h7F, 1'b1, 4'hF, 1'b0};

    function automatic logic [6:0] ref_hex(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expected pins for a lit cycle of slot i, given the frame snapshot.
    function automatic logic [12:0] lit_word(input int i, input logic [15:0] s,
                                             input logic [3:0] dpm, input bit fd);
        bit         b3, b2, b1, bl;
        logic [3:0] dv;
        logic [6:0] sa;
        logic [3:0] c;
        b3 = (s[15:12] == 4'h0);
        b2 = b3 && (s[11:8] == 4'h0);
        b1 = b2 && (s[7:4] == 4'h0);
        bl = (i == 3) ? b3 : (i == 2) ? b2 : (i == 1) ? b1 : 1'b0;
        dv = s[i*4 +: 4];
        sa = bl ? 7'h00 : ref_hex(dv);
        c  = 4'hF;
        c[i] = 1'b0;
        return {~sa, ~dpm[i], c, fd};
    endfunction

    task automatic push_dark(input int n);
        ent_t e;
        for (int k = 0; k < n; k++) begin
            e = '{exp: DARK, act: 1'b0, a_en: 1'b0, a_rst: 1'b0, a_dig: 16'h0, a_dpm: 4'h0};
            sb.push_back(e);
        end
    endtask

    task automatic push_lit(input int i, input logic [15:0] s, input logic [3:0] dpm,
                            input int n, input bit fd_last);
        ent_t e;
        for (int k = 0; k < n; k++) begin
            e = '{exp: lit_word(i, s, dpm, fd_last && (k == n - 1)), act: 1'b0,
                  a_en: 1'b0, a_rst: 1'b0, a_dig: 16'h0, a_dpm: 4'h0};
            sb.push_back(e);
        end
    endtask

    task automatic push_action(input logic a_en, input logic a_rst,
                               input logic [15:0] a_dig, input logic [3:0] a_dpm);
        ent_t e;
        e       = sb[sb.size() - 1];
        e.act   = 1'b1;
        e.a_en  = a_en;
        e.a_rst = a_rst;
        e.a_dig = a_dig;
        e.a_dpm = a_dpm;
        sb[sb.size() - 1] = e;
    endtask

    // One frame of expected output. 'first' adds the IDLE cycle in which the
    // enable is seen; do_act changes the inputs midway through slot 2.
    task automatic push_frame(input bit first, input logic [15:0] s, input logic [3:0] dpm,
                              input bit do_act, input logic [15:0] ns, input logic [3:0] ndpm);
        if (first) push_dark(1);
        for (int i = 0; i < 4; i++) begin
            push_dark(2);
            if (i == 2 && do_act) begin
                push_lit(2, s, dpm, 4, 1'b0);
                push_action(1'b1, 1'b0, ns, ndpm);
                push_lit(2, s, dpm, 4, 1'b0);
            end else begin
                push_lit(i, s, dpm, 8, i == 3);
            end
        end
    endtask

    task automatic run_check(input string name);
        ent_t        e;
        logic [12:0] got;
        int          cyc;
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {seg, dp, com, frame_done};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s cyc %0d got seg=%h dp=%b com=%h fd=%b want seg=%h dp=%b com=%h fd=%b",
                         name, cyc, got[12:6], got[5], got[4:1], got[0],
                         e.exp[12:6], e.exp[5], e.exp[4:1], e.exp[0]);
            end
            if (e.act) begin
                en                         = e.a_en;
                rst                        = e.a_rst;
                {dig3, dig2, dig1, dig0}   = e.a_dig;
                dp_mask                    = e.a_dpm;
            end
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start(input logic [15:0] s, input logic [3:0] dpm);
        do_reset();
        {dig3, dig2, dig1, dig0} = s;
        dp_mask = dpm;
        en      = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        {dig3, dig2, dig1, dig0} = 16'($urandom);
        dp_mask = 4'hF;
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        got = {seg, dp, com, frame_done};
        checks++;
        if (got !== DARK) begin
            errors++;
            $display("FAIL reset got %h want %h", got, DARK);
        end
        rst = 1'b0;
        en  = 1'b0;
        push_dark(50);
        run_check("idle");
    endtask

    task automatic test_basic();
        start(16'h1234, 4'h0);
        push_frame(1'b1, 16'h1234, 4'h0, 1'b0, 16'h0, 4'h0);
        push_frame(1'b0, 16'h1234, 4'h0, 1'b0, 16'h0, 4'h0);
        run_check("basic");
    endtask

    task automatic test_snapshot();
        start(16'h1234, 4'h0);
        push_frame(1'b1, 16'h1234, 4'h0, 1'b1, 16'h1239, 4'h0);
        push_frame(1'b0, 16'h1239, 4'h0, 1'b0, 16'h0, 4'h0);
        run_check("snapshot");
    endtask

    task automatic test_blank();
        start(16'h0000, 4'h0);
        push_frame(1'b1, 16'h0000, 4'h0, 1'b1, 16'h0500, 4'h0);
        push_frame(1'b0, 16'h0500, 4'h0, 1'b0, 16'h0, 4'h0);
        run_check("blank");
    endtask

    task automatic test_hex_dp();
        start(16'h000B, 4'b0001);
        push_frame(1'b1, 16'h000B, 4'b0001, 1'b1, 16'hFEDC, 4'b1010);
        push_frame(1'b0, 16'hFEDC, 4'b1010, 1'b1, 16'h9876, 4'b0100);
        push_frame(1'b0, 16'h9876, 4'b0100, 1'b1, 16'h05A1, 4'b1000);
        push_frame(1'b0, 16'h05A1, 4'b1000, 1'b0, 16'h0, 4'h0);
        run_check("hex_dp");
    endtask

    task automatic test_abort();
        start(16'h1234, 4'h0);
        push_dark(1);
        push_dark(2);
        push_lit(0, 16'h1234, 4'h0, 8, 1'b0);
        push_dark(2);
        push_lit(1, 16'h1234, 4'h0, 3, 1'b0);
        push_action(1'b0, 1'b0, 16'h1234, 4'h0);
        push_lit(1, 16'h1234, 4'h0, 1, 1'b0);
        push_dark(50);
        run_check("abort_en");
    endtask

    task automatic test_rst_mid();
        start(16'h1234, 4'h0);
        push_dark(1);
        for (int i = 0; i < 2; i++) begin
            push_dark(2);
            push_lit(i, 16'h1234, 4'h0, 8, 1'b0);
        end
        push_dark(2);
        push_lit(2, 16'h1234, 4'h0, 3, 1'b0);
        push_action(1'b1, 1'b1, 16'h1234, 4'h0);
        push_dark(1);
        push_action(1'b1, 1'b0, 16'h1234, 4'h0);
        push_frame(1'b1, 16'h1234, 4'h0, 1'b0, 16'h0, 4'h0);
        run_check("rst_mid");
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        dig0    = 4'h0;
        dig1    = 4'h0;
        dig2    = 4'h0;
        dig3    = 4'h0;
        dp_mask = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_snapshot();
        test_blank();
        test_hex_dp();
        test_abort();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
